// File: rtl/pipeline_stall_ctrl_if.sv
// Datapath/cache/DMA signal bundle for the pipeline stall controller.
// The bench drives the master side; the controller takes the slave side.
interface pipeline_stall_ctrl_if #(
  parameter int REG_ADDR_W = 2,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] rs_addr, rt_addr, destEX, destM, destWB;
  logic                  use_rs, use_rt, is_halt_ID, is_load_EX;
  logic                  RegWrite_EX, RegWrite_M, RegWrite_WB;
  logic                  i_cache_hit, d_cache_hit, i_ready, d_ready;
  logic                  BR, clr_stats;
  logic                  BG, PCWrite, IDWrite, EXWrite, MWrite, WBWrite;
  logic                  flush_EX, both_access;
  logic [1:0]            forwardSrcA, forwardSrcB;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output rs_addr, rt_addr, destEX, destM, destWB, use_rs, use_rt, is_halt_ID, is_load_EX,
           RegWrite_EX, RegWrite_M, RegWrite_WB, i_cache_hit, d_cache_hit, i_ready, d_ready,
           BR, clr_stats,
    input  BG, PCWrite, IDWrite, EXWrite, MWrite, WBWrite, flush_EX, both_access,
           forwardSrcA, forwardSrcB, stall_cycles
  );

  modport slave (
    input  rs_addr, rt_addr, destEX, destM, destWB, use_rs, use_rt, is_halt_ID, is_load_EX,
           RegWrite_EX, RegWrite_M, RegWrite_WB, i_cache_hit, d_cache_hit, i_ready, d_ready,
           BR, clr_stats,
    output BG, PCWrite, IDWrite, EXWrite, MWrite, WBWrite, flush_EX, both_access,
           forwardSrcA, forwardSrcB, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for the 5-stage CPU: latch enables, ID/EX bubbles,
// forwarding selects, I/D refill sequencing and the DMA BR/BG bus grant.
module pipeline_stall_ctrl #(
  parameter int REG_ADDR_W     = 2,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ACCESS_I = 3'd1;
  localparam logic [2:0] S_ACCESS_D = 3'd2;
  localparam logic [2:0] S_BOTH     = 3'd3;
  localparam logic [2:0] S_LSTALL   = 3'd4;
  localparam logic [2:0] S_GRANT    = 3'd5;

  // Enable vectors ordered {PC, ID, EX, M, WB}.
  localparam logic [4:0] EN_RUN  = 5'b11111;
  localparam logic [4:0] EN_BUB  = 5'b00111;
  localparam logic [4:0] EN_HOLD = 5'b00000;

  localparam logic [3:0]       CNT_INIT = 4'(LOAD_USE_STALL - 1);
  localparam logic [CNT_W-1:0] STAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             i_done_q, i_done_d, d_done_q, d_done_d;
  logic             bg_q;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [4:0]       en_c, en_o;
  logic             flush_c, both_c, hazard;

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic                  src_use  [2];
  logic [1:0]            fwd_sel  [2];
  logic [1:0]            ex_match;

  assign src_addr[0] = bus.rs_addr;
  assign src_addr[1] = bus.rt_addr;
  assign src_use[0]  = bus.use_rs;
  assign src_use[1]  = bus.use_rt;

  // Youngest producer wins: EX over MEM over WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_ex, hit_m, hit_wb;
    assign hit_ex       = src_use[gi] & bus.RegWrite_EX & (src_addr[gi] == bus.destEX);
    assign hit_m        = src_use[gi] & bus.RegWrite_M  & (src_addr[gi] == bus.destM);
    assign hit_wb       = src_use[gi] & bus.RegWrite_WB & (src_addr[gi] == bus.destWB);
    assign fwd_sel[gi]  = hit_ex ? 2'd1 : hit_m ? 2'd2 : hit_wb ? 2'd3 : 2'd0;
    assign ex_match[gi] = hit_ex;
  end

  assign hazard = bus.is_load_EX & (|ex_match);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    en_c     = EN_RUN;
    flush_c  = 1'b0;
    both_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.BR && bus.i_cache_hit && bus.d_cache_hit) begin
          state_d = S_GRANT;
          en_c    = EN_HOLD;
        end else if (!bus.d_cache_hit) begin
          state_d = bus.i_cache_hit ? S_ACCESS_D : S_BOTH;
          en_c    = EN_HOLD;
        end else if (!bus.i_cache_hit) begin
          state_d = S_ACCESS_I;
          en_c    = EN_BUB;
          flush_c = 1'b1;
        end else if (hazard) begin
          en_c    = EN_BUB;
          flush_c = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            state_d = S_LSTALL;
            cnt_d   = CNT_INIT;
          end
        end else if (bus.is_halt_ID) begin
          en_c = EN_BUB;
        end
      end
      S_ACCESS_I: begin
        if (!bus.d_cache_hit) begin
          state_d  = S_BOTH;
          en_c     = EN_HOLD;
          i_done_d = 1'b1;
        end else if (bus.i_ready) begin
          state_d = S_IDLE;
        end else begin
          en_c    = EN_BUB;
          flush_c = 1'b1;
        end
      end
      S_ACCESS_D: begin
        en_c = EN_HOLD;
        if (!bus.i_cache_hit) begin
          state_d  = S_BOTH;
          d_done_d = 1'b1;
        end else if (bus.d_ready) begin
          state_d = S_IDLE;
          en_c    = EN_RUN;
        end
      end
      S_BOTH: begin
        // A ready pulse in the exit cycle counts as if it had already been latched.
        if ((i_done_q | bus.i_ready) && (d_done_q | bus.d_ready)) begin
          state_d  = S_IDLE;
          i_done_d = 1'b0;
          d_done_d = 1'b0;
        end else begin
          en_c     = EN_HOLD;
          both_c   = 1'b1;
          i_done_d = i_done_q | bus.i_ready;
          d_done_d = d_done_q | bus.d_ready;
        end
      end
      S_LSTALL: begin
        en_c    = EN_BUB;
        flush_c = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      S_GRANT: begin
        en_c = EN_HOLD;
        if (!bus.BR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset forces the pipeline to free-run so the datapath can flush itself.
  assign en_o = reset_n ? en_c : EN_RUN;

  always_comb begin
    stall_d = stall_q;
    if (bus.clr_stats) stall_d = '0;
    else if (!en_o[4] && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + STAT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      bg_q     <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      bg_q     <= (state_d == S_GRANT);
      stall_q  <= stall_d;
    end
  end

  // BG falls in the same cycle BR is withdrawn; its rise waits for the grant state.
  assign bus.BG           = bg_q & bus.BR;
  assign bus.PCWrite      = en_o[4];
  assign bus.IDWrite      = en_o[3];
  assign bus.EXWrite      = en_o[2];
  assign bus.MWrite       = en_o[1];
  assign bus.WBWrite      = en_o[0];
  assign bus.flush_EX     = reset_n & flush_c;
  assign bus.both_access  = both_c;
  assign bus.forwardSrcA  = fwd_sel[0];
  assign bus.forwardSrcB  = fwd_sel[1];
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, corner-case sequences
// and a random run, all checked against a behavioural model of the controller.
module tb_pipeline_stall_ctrl;
  localparam int LUS       = 2;
  localparam int CNT_W     = 8;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  localparam logic [4:0] RUN  = 5'b11111;
  localparam logic [4:0] BUB  = 5'b00111;
  localparam logic [4:0] HOLD = 5'b00000;

  localparam int M_RUN = 0, M_REFILL = 1, M_STALL = 2, M_GRANT = 3;

  typedef struct {
    logic [1:0] rs, rt, dex, dm, dwb;
    logic use_rs, use_rt, halt, ld, rwe, rwm, rwwb, ih, dh, ir, dr, br, clr;
  } in_t;

  typedef struct {
    in_t        v;
    logic [4:0] en;
    logic       fl;
    logic [1:0] fa, fb;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_stall_ctrl_if #(.REG_ADDR_W(2), .CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(.REG_ADDR_W(2), .LOAD_USE_STALL(LUS), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the controller is doing, not how it encodes it.
  int  m_mode;
  bit  m_need_i, m_need_d, m_dual, m_bg;
  int  m_bub;
  int  m_stall;

  // Last sampled DUT outputs, for the sequence-level checks.
  logic [4:0]       a_en;
  logic             a_fl, a_both, a_bg;
  logic [1:0]       a_fa, a_fb;
  logic [CNT_W-1:0] a_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [1:0] rs, rt, input logic ur, ut, halt, ld,
                             input logic [1:0] dex, dm, dwb, input logic rwe, rwm, rwwb, ih, dh, br);
    in_t v;
    v.rs = rs; v.rt = rt; v.use_rs = ur; v.use_rt = ut; v.halt = halt; v.ld = ld;
    v.dex = dex; v.dm = dm; v.dwb = dwb; v.rwe = rwe; v.rwm = rwm; v.rwwb = rwwb;
    v.ih = ih; v.dh = dh; v.br = br; v.ir = 1'b0; v.dr = 1'b0; v.clr = 1'b0;
    return v;
  endfunction

  function automatic in_t idle_in();
    return mk(2'd1, 2'd2, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0);
  endfunction

  function automatic logic [1:0] fwd(input logic u, input logic [1:0] a, input in_t v);
    if (u && v.rwe && a == v.dex) return 2'd1;
    if (u && v.rwm && a == v.dm) return 2'd2;
    if (u && v.rwwb && a == v.dwb) return 2'd3;
    return 2'd0;
  endfunction

  task automatic apply(input in_t v);
    bus.rs_addr = v.rs; bus.rt_addr = v.rt; bus.use_rs = v.use_rs; bus.use_rt = v.use_rt;
    bus.is_halt_ID = v.halt; bus.is_load_EX = v.ld;
    bus.destEX = v.dex; bus.destM = v.dm; bus.destWB = v.dwb;
    bus.RegWrite_EX = v.rwe; bus.RegWrite_M = v.rwm; bus.RegWrite_WB = v.rwwb;
    bus.i_cache_hit = v.ih; bus.d_cache_hit = v.dh; bus.i_ready = v.ir; bus.d_ready = v.dr;
    bus.BR = v.br; bus.clr_stats = v.clr;
  endtask

  task automatic sample();
    a_en    = {bus.PCWrite, bus.IDWrite, bus.EXWrite, bus.MWrite, bus.WBWrite};
    a_fl    = bus.flush_EX;
    a_fa    = bus.forwardSrcA;
    a_fb    = bus.forwardSrcB;
    a_both  = bus.both_access;
    a_bg    = bus.BG;
    a_stall = bus.stall_cycles;
  endtask

  // Asserts reset with the previous inputs still applied, checks the reset
  // outputs (including the asynchronous BG drop), then releases it.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sample();
    chk("reset_outs", {a_en, a_fl, a_bg, a_both}, {RUN, 1'b0, 1'b0, 1'b0});
    chk("reset_stall", 32'(a_stall), 32'd0);
    apply(idle_in());
    m_mode = M_RUN; m_need_i = 0; m_need_d = 0; m_dual = 0; m_bg = 0; m_bub = 0; m_stall = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict, compare, advance the model.
  task automatic step(input in_t v);
    logic [4:0] e_en;
    logic       e_fl, e_both, e_bg, hz;
    logic [1:0] e_fa, e_fb;
    int         n_mode, n_bub;
    bit         n_i, n_d, n_dual;
    @(negedge clk);
    apply(v);
    #2;
    e_fa = fwd(v.use_rs, v.rs, v);
    e_fb = fwd(v.use_rt, v.rt, v);
    hz   = v.ld && (e_fa == 2'd1 || e_fb == 2'd1);
    n_mode = m_mode; n_bub = m_bub; n_i = m_need_i; n_d = m_need_d; n_dual = m_dual;
    e_en = RUN; e_fl = 1'b0; e_both = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (v.br && v.ih && v.dh) begin
          e_en = HOLD; n_mode = M_GRANT;
        end else if (!v.dh) begin
          e_en = HOLD; n_mode = M_REFILL; n_dual = !v.ih; n_i = !v.ih; n_d = 1;
        end else if (!v.ih) begin
          e_en = BUB; e_fl = 1; n_mode = M_REFILL; n_dual = 0; n_i = 1; n_d = 0;
        end else if (hz) begin
          e_en = BUB; e_fl = 1;
          if (LUS > 1) begin n_mode = M_STALL; n_bub = LUS - 1; end
        end else if (v.halt) begin
          e_en = 5'b00111;
        end
      end
      M_REFILL: begin
        if (!m_dual && m_need_i) begin
          // The side already in flight is treated as done once the second miss arrives.
          if (!v.dh) begin e_en = HOLD; n_dual = 1; n_i = 0; n_d = 1; end
          else if (v.ir) n_mode = M_RUN;
          else begin e_en = BUB; e_fl = 1; end
        end else if (!m_dual) begin
          if (!v.ih) begin e_en = HOLD; n_dual = 1; n_i = 1; n_d = 0; end
          else if (v.dr) n_mode = M_RUN;
          else e_en = HOLD;
        end else begin
          n_i = m_need_i && !v.ir;
          n_d = m_need_d && !v.dr;
          if (!n_i && !n_d) begin n_mode = M_RUN; n_dual = 0; end
          else begin e_en = HOLD; e_both = 1; end
        end
      end
      M_STALL: begin
        e_en = BUB; e_fl = 1; n_bub = m_bub - 1;
        if (n_bub == 0) n_mode = M_RUN;
      end
      default: begin
        e_en = HOLD;
        if (!v.br) n_mode = M_RUN;
      end
    endcase
    e_bg = m_bg && v.br;
    sample();
    chk("outs", {a_en, a_fl, a_fa, a_fb, a_both, a_bg}, {e_en, e_fl, e_fa, e_fb, e_both, e_bg});
    chk("stall_cycles", 32'(a_stall), 32'(m_stall));
    @(posedge clk);
    if (v.clr) m_stall = 0;
    else if (!e_en[4] && m_stall < STALL_MAX) m_stall++;
    m_mode = n_mode; m_bub = n_bub; m_need_i = n_i; m_need_d = n_d; m_dual = n_dual;
    m_bg = (n_mode == M_GRANT);
  endtask

  vec_t tbl[13];

  initial begin
    in_t        v;
    int         nb;
    logic [7:0] hold_mask, both_mask, bg_mask;
    bit         br_q;

    tbl[0]  = '{mk(1,2,1,1,0,0, 3,0,0, 1,1,1, 1,1,0), RUN,  0, 2'd0, 2'd0};
    tbl[1]  = '{mk(1,2,1,1,0,0, 1,2,3, 1,1,1, 1,1,0), RUN,  0, 2'd1, 2'd2};
    tbl[2]  = '{mk(1,1,1,0,0,0, 1,1,1, 1,1,1, 1,1,0), RUN,  0, 2'd1, 2'd0};
    tbl[3]  = '{mk(1,3,1,1,0,0, 1,1,3, 0,1,1, 1,1,0), RUN,  0, 2'd2, 2'd3};
    tbl[4]  = '{mk(1,2,1,1,0,1, 1,0,0, 1,0,0, 1,1,0), BUB,  1, 2'd1, 2'd0};
    tbl[5]  = '{mk(1,2,1,1,0,1, 3,0,2, 1,0,1, 1,1,0), RUN,  0, 2'd0, 2'd3};
    tbl[6]  = '{mk(1,2,1,1,1,0, 0,0,0, 0,0,0, 1,1,0), BUB,  0, 2'd0, 2'd0};
    tbl[7]  = '{mk(2,2,0,1,1,1, 2,0,0, 1,0,0, 1,1,0), BUB,  1, 2'd0, 2'd1};
    tbl[8]  = '{mk(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0), BUB,  1, 2'd0, 2'd0};
    tbl[9]  = '{mk(0,0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0), HOLD, 0, 2'd0, 2'd0};
    tbl[10] = '{mk(1,2,1,1,0,1, 1,0,0, 1,0,0, 1,1,1), HOLD, 0, 2'd1, 2'd0};
    tbl[11] = '{mk(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,1), BUB,  1, 2'd0, 2'd0};
    tbl[12] = '{mk(0,2,0,1,0,0, 2,2,2, 1,1,1, 1,1,0), RUN,  0, 2'd0, 2'd1};

    apply(idle_in());
    m_mode = M_RUN; m_need_i = 0; m_need_d = 0; m_dual = 0; m_bg = 0; m_bub = 0; m_stall = 0;

    for (int i = 0; i < 13; i++) begin
      do_reset();
      step(tbl[i].v);
      chk($sformatf("vec%0d", i), {a_en, a_fl, a_fa, a_fb}, {tbl[i].en, tbl[i].fl, tbl[i].fa, tbl[i].fb});
      $display("vec %0d: en=%b flush=%b fa=%0d fb=%0d", i, a_en, a_fl, a_fa, a_fb);
    end

    // Load-use with two bubbles, then MEM and WB forwarding.
    do_reset();
    nb = 0;
    v = idle_in(); v.ld = 1; v.rs = 2'd1; v.dex = 2'd1; v.rwe = 1;
    step(v); if (a_en == BUB && a_fl) nb++;
    v.ld = 0; v.rwe = 0; v.dm = 2'd1; v.rwm = 1;
    step(v); if (a_en == BUB && a_fl) nb++;
    step(v);
    chk("t1_bubbles", 32'(nb), 32'd2);
    chk("t1_mem_fwd", {a_en, a_fa}, {RUN, 2'd2});
    v.rwm = 0; v.dwb = 2'd1; v.rwwb = 1;
    step(v);
    chk("t1_wb_fwd", 32'(a_fa), 32'd3);
    $display("t1 load-use: bubbles=%0d", nb);

    // I-miss serviced in six bubble cycles.
    do_reset();
    nb = 0;
    for (int k = 0; k <= 6; k++) begin
      v = idle_in(); v.ih = (k == 6); v.ir = (k == 6);
      step(v);
      if (k < 6 && a_en == BUB && a_fl) nb++;
    end
    chk("t2_bubbles", 32'(nb), 32'd6);
    chk("t2_run", {a_en, a_fl}, {RUN, 1'b0});
    step(idle_in());
    chk("t2_stall_cycles", 32'(a_stall), 32'd6);
    $display("t2 i-miss: bubbles=%0d stall_cycles=%0d", nb, a_stall);

    // D-miss then I-miss overlapping.
    do_reset();
    hold_mask = '0; both_mask = '0;
    for (int k = 0; k <= 7; k++) begin
      v = idle_in();
      v.dh = (k >= 4); v.dr = (k == 4);
      v.ih = !(k >= 2 && k <= 6); v.ir = (k == 7);
      step(v);
      hold_mask[k] = (a_en == HOLD);
      both_mask[k] = a_both;
    end
    chk("t3_hold", 32'(hold_mask), 32'h7F);
    chk("t3_both", 32'(both_mask), 32'h78);
    $display("t3 dual refill: hold=%b both=%b", hold_mask, both_mask);

    // Bus grant.
    do_reset();
    bg_mask = '0; hold_mask = '0;
    for (int k = 0; k <= 6; k++) begin
      v = idle_in(); v.br = (k <= 4);
      step(v);
      bg_mask[k] = a_bg;
      hold_mask[k] = (a_en == HOLD);
    end
    chk("t4_bg", 32'(bg_mask), 32'h1E);
    chk("t4_hold", 32'(hold_mask), 32'h3F);
    $display("t4 grant: bg=%b hold=%b", bg_mask, hold_mask);

    // Hazard and BR together: grant first, bubble afterwards.
    do_reset();
    v = idle_in(); v.ld = 1; v.dex = 2'd1; v.rwe = 1; v.br = 1;
    step(v);
    chk("t5_grant_first", {a_en, a_fl}, {HOLD, 1'b0});
    step(v); step(v);
    v.br = 0;
    step(v);
    step(v);
    chk("t5_bubble_after", {a_en, a_fl}, {BUB, 1'b1});
    $display("t5 hazard+grant: en=%b flush=%b", a_en, a_fl);

    // Reset in the middle of a dual refill clears the sticky flags.
    do_reset();
    v = idle_in(); v.ih = 0; v.dh = 0;
    step(v);
    v.dr = 1; step(v);
    v.dr = 0; step(v);
    do_reset();
    v = idle_in(); v.ih = 0; v.dh = 0;
    step(v);
    v.ir = 1; step(v);
    chk("t6_flags_cleared", 32'(a_en), 32'(HOLD));
    v.ir = 0; v.dr = 1; step(v);
    chk("t6_exit", 32'(a_en), 32'(RUN));
    // Reset during grant with BR still high.
    v = idle_in(); v.br = 1;
    step(v); step(v);
    chk("t6_bg_before_reset", 32'(a_bg), 32'd1);
    do_reset();
    $display("t6 reset mid-refill/grant done");

    // Counter saturation and clear.
    v = idle_in(); v.br = 1;
    for (int k = 0; k < STALL_MAX + 6; k++) step(v);
    chk("t6_saturate", 32'(a_stall), 32'(STALL_MAX));
    v.clr = 1; step(v);
    v.clr = 0; step(v);
    chk("t6_clear", 32'(a_stall), 32'd0);
    $display("t6 saturation: stall_cycles cleared after holding at %0d", STALL_MAX);

    // Random traffic against the model.
    do_reset();
    br_q = 0;
    for (int k = 0; k < 3000; k++) begin
      v.rs = 2'($urandom); v.rt = 2'($urandom);
      v.dex = 2'($urandom); v.dm = 2'($urandom); v.dwb = 2'($urandom);
      v.use_rs = 1'($urandom); v.use_rt = 1'($urandom);
      v.rwe = 1'($urandom); v.rwm = 1'($urandom); v.rwwb = 1'($urandom);
      v.ld = ($urandom_range(0, 2) == 0);
      v.halt = ($urandom_range(0, 7) == 0);
      v.ih = ($urandom_range(0, 5) != 0);
      v.dh = ($urandom_range(0, 7) != 0);
      v.ir = ($urandom_range(0, 3) == 0);
      v.dr = ($urandom_range(0, 3) == 0);
      br_q = ($urandom_range(0, 3) == 0) ? !br_q : br_q;
      v.br = br_q;
      v.clr = ($urandom_range(0, 99) == 0);
      step(v);
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    $display("random: 3000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
